// File: rtl/uart_pkg.sv
// Shared definitions for the UART word receiver: bit-FSM encoding and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 receiver: synchronises rx, frames one byte and strobes it (or a framing error).
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 byte_stb_o,
  output logic                 frame_err_o,
  output logic                 idle_o,
  output logic                 start_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS + 1);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 sync1_q, rx_s_q, rx_prev_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;

  // Synchroniser resets low so a line held low across reset is never mistaken for a fresh start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      rx_s_q    <= 1'b0;
      rx_prev_q <= 1'b0;
      state_q   <= ST_WAIT_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      sync1_q   <= rx_i;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_stb_o  = 1'b0;
    frame_err_o = 1'b0;
    start_o     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = ST_START;
          start_o = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_stb_o = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            frame_err_o = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_WAIT_IDLE;
      end
    endcase
  end

  assign byte_o = shift_q;
  assign idle_o = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_word_rx.sv
// Assembles received UART bytes into words with inter-byte timeout and a valid/ready output.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int WORD_BYTES   = 4,
  parameter int MSB_FIRST    = 0,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [8*WORD_BYTES-1:0]   m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      frame_err,
  output logic                      timeout,
  output logic                      overrun
);

  localparam int WORD_W   = DATA_BITS * WORD_BYTES;
  localparam int BCNT_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);

  logic [DATA_BITS-1:0] rx_byte;
  logic                 byte_stb, byte_ferr, fsm_idle, start_det;

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WORD_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic              to_hit, word_done;
  int                byte_pos;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx),
    .byte_o     (rx_byte),
    .byte_stb_o (byte_stb),
    .frame_err_o(byte_ferr),
    .idle_o     (fsm_idle),
    .start_o    (start_det)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q      <= '0;
      asm_q       <= '0;
      idle_cnt_q  <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      bcnt_q      <= bcnt_d;
      asm_q       <= asm_d;
      idle_cnt_q  <= idle_cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    idle_cnt_d  = idle_cnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    overrun_d   = 1'b0;
    word_done   = 1'b0;
    byte_pos    = 0;

    if (start_det) begin
      idle_cnt_d = '0;
    end else if (fsm_idle && (bcnt_q != '0)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    to_hit = fsm_idle && (bcnt_q != '0) && !start_det && (idle_cnt_q == TO_LAST);

    // A framing error outranks a timeout; both discard the partial word.
    if (byte_ferr) begin
      frame_err_d = 1'b1;
      bcnt_d      = '0;
    end else if (to_hit) begin
      timeout_d  = 1'b1;
      bcnt_d     = '0;
      idle_cnt_d = '0;
    end else if (byte_stb) begin
      byte_pos = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - int'(bcnt_q)) : int'(bcnt_q);
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (b == byte_pos) asm_d[DATA_BITS*b +: DATA_BITS] = rx_byte;
      end
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d    = '0;
        word_done = 1'b1;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (word_done) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = asm_d;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx: one LSB-first and one MSB-first instance share the serial line.
module tb_uart_word_rx;

  localparam int CPB = 16;
  localparam int WB  = 4;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        m_ready = 1'b1;
  logic [31:0] m_data0, m_data1;
  logic        m_valid0, m_valid1;
  logic        ferr0, ferr1, to0, to1, ov0, ov1;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          fe_n[2];
  int          to_n[2];
  int          ov_n[2];
  bit          lat_chk = 1'b0;
  int          lat_exp = 0;

  uart_word_rx #(
    .CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .MSB_FIRST(0), .TIMEOUT_BITS(TOB)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready), .frame_err(ferr0), .timeout(to0), .overrun(ov0)
  );

  uart_word_rx #(
    .CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .MSB_FIRST(1), .TIMEOUT_BITS(TOB)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready), .frame_err(ferr1), .timeout(to1), .overrun(ov1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop_ok;
    cycles(CPB);
    rx = 1'b1;
  endtask

  // Stop sample of the last byte lands 154 cycles after its start edge; m_valid shows one cycle later.
  task automatic send_word(input logic [31:0] w, input bit expect_it, input bit do_lat);
    if (expect_it) begin
      q0.push_back(w);
      q1.push_back(rev(w));
    end
    for (int k = 0; k < WB; k++) begin
      if (do_lat && k == WB - 1) begin
        lat_exp = cyc + 155;
        lat_chk = 1'b1;
      end
      send_byte(w[8*k +: 8], 1'b1);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 2000) begin
      cycles(1);
      t++;
    end
    chk({name, " pending words"}, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic check_pulses(input string name, input int fe, input int tmo, input int ov);
    for (int d = 0; d < 2; d++) begin
      chk({name, " frame_err count"}, 32'(fe_n[d]), 32'(fe));
      chk({name, " timeout count"}, 32'(to_n[d]), 32'(tmo));
      chk({name, " overrun count"}, 32'(ov_n[d]), 32'(ov));
    end
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, " m_valid0"}, 32'(m_valid0), 32'd0);
    chk({name, " m_data0"}, m_data0, 32'd0);
    chk({name, " pulses0"}, 32'({ferr0, to0, ov0}), 32'd0);
    chk({name, " m_valid1"}, 32'(m_valid1), 32'd0);
    chk({name, " m_data1"}, m_data1, 32'd0);
    chk({name, " pulses1"}, 32'({ferr1, to1, ov1}), 32'd0);
  endtask

  // Monitor: counts pulses and pops the scoreboard on every accepted transfer.
  initial begin
    for (int d = 0; d < 2; d++) begin
      fe_n[d] = 0;
      to_n[d] = 0;
      ov_n[d] = 0;
    end
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ferr0) fe_n[0]++;
        if (ferr1) fe_n[1]++;
        if (to0) to_n[0]++;
        if (to1) to_n[1]++;
        if (ov0) ov_n[0]++;
        if (ov1) ov_n[1]++;
        if (lat_chk && m_valid0) begin
          chk("valid latency", 32'(cyc), 32'(lat_exp));
          lat_chk = 1'b0;
        end
        if (m_valid0 && m_ready) begin
          if (q0.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut0 unexpected word: got 0x%08h expected none", m_data0);
          end else begin
            chk("dut0 word", m_data0, q0.pop_front());
          end
        end
        if (m_valid1 && m_ready) begin
          if (q1.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut1 unexpected word: got 0x%08h expected none", m_data1);
          end else begin
            chk("dut1 word", m_data1, q1.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    m_ready = 1'b1;
    cycles(3);
    check_outputs_zero("in reset");
    rst_n = 1'b1;
    cycles(8);
    check_outputs_zero("after reset");

    // LSB-first word with latency and single-cycle valid
    send_word(32'h04030201, 1'b1, 1'b1);
    drain("word 04030201");
    chk("latency seen", 32'(lat_chk), 32'd0);
    check_pulses("word1", 0, 0, 0);

    // byte order: dut1 assembles MSB-first
    send_word(32'h44332211, 1'b1, 1'b0);
    drain("word 11223344");
    check_pulses("word2", 0, 0, 0);

    // framing error on second byte, then a clean word
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    cycles(2 * CPB);
    check_pulses("frame error", 1, 0, 0);
    send_word(32'hDDCCBBAA, 1'b1, 1'b0);
    drain("word after frame error");

    // partial word timeout
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    cycles(400);
    check_pulses("timeout", 1, 1, 0);
    send_word(32'h08070605, 1'b1, 1'b0);
    drain("word after timeout");
    check_pulses("post timeout", 1, 1, 0);

    // back-pressure: second word overruns
    m_ready = 1'b0;
    send_word(32'h04030201, 1'b1, 1'b0);
    send_word(32'h08070605, 1'b0, 1'b0);
    cycles(4);
    check_pulses("overrun", 1, 1, 1);
    chk("held valid0", 32'(m_valid0), 32'd1);
    chk("held data0", m_data0, 32'h04030201);
    chk("held data1", m_data1, 32'h01020304);
    m_ready = 1'b1;
    cycles(2);
    drain("overrun release");
    chk("valid0 after transfer", 32'(m_valid0), 32'd0);
    chk("valid1 after transfer", 32'(m_valid1), 32'd0);

    // short low glitch is rejected
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(200);
    check_pulses("glitch", 1, 1, 1);
    chk("glitch valid0", 32'(m_valid0), 32'd0);

    // reset mid-byte with the line held low across release
    rx = 1'b0;
    cycles(CPB + 40);
    rst_n = 1'b0;
    cycles(2);
    check_outputs_zero("mid-byte reset");
    rst_n = 1'b1;
    cycles(40);
    rx = 1'b1;
    cycles(32);
    check_outputs_zero("after mid-byte reset");
    check_pulses("after mid-byte reset", 1, 1, 1);
    send_word(32'h0D0C0B0A, 1'b1, 1'b0);
    drain("word after reset");
    check_pulses("final", 1, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
